fifo_burst_rd_ctrl: RTL and testbench
=====================================

FIFO_BURST_RD_CTRL -- requirements
Module: fifo_burst_rd_ctrl

Interface
REQ-001: Parameter RD_DATA_WIDTH, default 16, is the FIFO read-side data width and the output data width.
REQ-002: Parameter RD_DEPTH_WIDTH, default 11, is the FIFO read address width; the water-level input is RD_DEPTH_WIDTH+1 bits wide.
REQ-003: Parameter BURST_LEN, default 64, legal 2..1024, is the full burst length in words.
REQ-004: Parameter TIMEOUT_CYC, default 256, legal 1..65535, is the idle cycles before a partial burst is flushed.
REQ-005: The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-006: Port rd_clk, input, 1 bit: the clock; all logic is rising-edge.
REQ-007: Port rd_rst_n, input, 1 bit: synchronous active-low reset.
REQ-008: Port enable, input, 1 bit: permits new bursts to start.
REQ-009: Port fifo_rd_en, output, 1 bit: FIFO read strobe.
REQ-010: Port fifo_rd_data, input, RD_DATA_WIDTH bits: FIFO read data, valid one cycle after fifo_rd_en (no output register).
REQ-011: Port fifo_rd_empty, input, 1 bit: FIFO empty flag.
REQ-012: Port fifo_rd_water_level, input, RD_DEPTH_WIDTH+1 bits: FIFO occupancy in words.
REQ-013: Port m_data, output, RD_DATA_WIDTH bits: downstream data.
REQ-014: Port m_valid, output, 1 bit: downstream data valid.
REQ-015: Port m_ready, input, 1 bit: downstream accept.
REQ-016: Port m_sop, output, 1 bit: first word of the burst.
REQ-017: Port m_eop, output, 1 bit: last word of the burst.
REQ-018: Port m_len, output, 11 bits: word count of the current burst.
REQ-019: Port busy, output, 1 bit: high when the state is not IDLE.
REQ-020: Port burst_cnt, output, 16 bits: count of completed bursts, wrapping.

Function
REQ-021: The state machine SHALL have states IDLE, BURST and GAP.
REQ-022: IDLE -> BURST SHALL occur when enable=1 and fifo_rd_water_level >= BURST_LEN; in that case len=BURST_LEN.
REQ-023: The idle timer SHALL increment each IDLE cycle with enable=1 and fifo_rd_empty=0, and SHALL clear otherwise and on leaving IDLE.
REQ-024: IDLE -> BURST SHALL occur when the timer reaches TIMEOUT_CYC-1 and no full burst is possible; in that case len=fifo_rd_water_level.
REQ-025: len SHALL be latched into m_len on the IDLE->BURST transition and held until the next burst starts.
REQ-026: In BURST, fifo_rd_en=1 only when issued<len, fifo_rd_empty=0, and (occ + inflight - pop) < 2.
- occ: occupancy of a 2-entry output buffer.
- inflight: registered previous fifo_rd_en.
- pop: m_valid & m_ready.
- fifo_rd_en SHALL be 0 in IDLE and GAP.
REQ-027: Returned data SHALL be written into the 2-entry buffer one cycle after fifo_rd_en; the buffer SHALL never overflow.
REQ-028: m_valid SHALL equal occ>0; m_data/m_sop/m_eop SHALL be held stable while m_valid=1 and m_ready=0.
REQ-029: m_sop SHALL mark output word index 0 and m_eop SHALL mark index len-1; both are high on the same word when len=1.
REQ-030: Sustained throughput SHALL be one word per cycle while m_ready=1 and the FIFO is not empty.
REQ-031: BURST -> GAP SHALL occur on the cycle the eop word is accepted; burst_cnt SHALL increment on that cycle.
REQ-032: GAP SHALL last exactly one cycle, then return to IDLE.
REQ-033: Deasserting enable mid-burst SHALL NOT abort the burst.
REQ-034: If fifo_rd_empty asserts mid-burst, reads SHALL stall and resume when it clears.
REQ-035: The issued and output counters SHALL be 11 bits and SHALL clear at burst start.

Reset
REQ-036: With rd_rst_n=0 at a clock edge, the block SHALL reset to:
- state IDLE, buffer empty, counters and timer zero;
- fifo_rd_en=0, m_valid=0, m_sop=0, m_eop=0, busy=0;
- m_data=0, m_len=0, burst_cnt=0.
REQ-037: Reset mid-burst SHALL discard buffered and in-flight words, with no output in the following cycle.

Verification
REQ-038: water_level=64, enable=1, m_ready=1 -> 64 consecutive valid words, sop on word 0, eop on word 63, m_len=64, burst_cnt=1, busy low 2 cycles after eop.
REQ-039: water_level=5 held, enable=1 -> after 256 idle cycles a 5-word burst, m_len=5, eop on word 4.
REQ-040: m_ready toggling 1/0 every cycle during a 64-word burst -> no word lost or duplicated, data in FIFO order, fifo_rd_en never lets occ exceed 2.
REQ-041: enable dropped at word 10 of a 64-word burst -> burst completes all 64 words; no new burst starts while enable=0.
REQ-042: rd_rst_n=0 at word 20 -> next cycle m_valid=0, busy=0, burst_cnt unchanged from before the burst, fifo_rd_en=0.
REQ-043: fifo_rd_empty forced high for 3 cycles at word 30 -> fifo_rd_en low for those cycles, burst resumes and ends with a correct eop at word 63.

Source files
------------

// File: rtl/fifo_burst_rd_ctrl_if.sv
// FIFO read port and downstream burst stream for fifo_burst_rd_ctrl.
// master = the controller, slave = the FIFO/sink side.
interface fifo_burst_rd_ctrl_if #(
    parameter int RD_DATA_WIDTH  = 16,
    parameter int RD_DEPTH_WIDTH = 11
);
    logic                     fifo_rd_en;
    logic [RD_DATA_WIDTH-1:0] fifo_rd_data;
    logic                     fifo_rd_empty;
    logic [RD_DEPTH_WIDTH:0]  fifo_rd_water_level;
    logic [RD_DATA_WIDTH-1:0] m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_sop;
    logic                     m_eop;
    logic [10:0]              m_len;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data, fifo_rd_empty, fifo_rd_water_level,
        output m_data, m_valid, m_sop, m_eop, m_len,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data, fifo_rd_empty, fifo_rd_water_level,
        input  m_data, m_valid, m_sop, m_eop, m_len,
        output m_ready
    );
endinterface

// File: rtl/fifo_burst_rd_ctrl.sv
// Burst read controller: pulls full (or timed-out partial) bursts out of a FIFO
// and presents them as a framed valid/ready stream through a 2-entry buffer.
module fifo_burst_rd_ctrl #(
    parameter int RD_DATA_WIDTH  = 16,
    parameter int RD_DEPTH_WIDTH = 11,
    parameter int BURST_LEN      = 64,
    parameter int TIMEOUT_CYC    = 256
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    input  logic                 enable,
    fifo_burst_rd_ctrl_if.master bus,
    output logic                 busy,
    output logic [15:0]          burst_cnt
);
    localparam logic [31:0] FULL_LEVEL = 32'(BURST_LEN);
    localparam logic [10:0] FULL_LEN   = 11'(BURST_LEN);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    typedef struct packed {
        logic [RD_DATA_WIDTH-1:0] data;
        logic                     sop;
        logic                     eop;
    } entry_t;

    state_t      state_reg;
    logic [15:0] timer_reg;
    logic [10:0] issued_reg;
    logic [10:0] out_cnt_reg;
    logic [10:0] len_reg;
    logic [15:0] burst_cnt_reg;
    logic [1:0]  occ_reg;
    logic        inflight_reg;
    logic        inflight_sop_reg;
    logic        inflight_eop_reg;
    entry_t      head_reg;
    entry_t      tail_reg;

    entry_t      in_entry;
    logic [10:0] last_idx;
    logic [10:0] level_len;
    logic        full_ok;
    logic        timeout_ok;
    logic        pop;
    logic        rd_en;

    always_comb begin
        in_entry   = '{data: bus.fifo_rd_data, sop: inflight_sop_reg, eop: inflight_eop_reg};
        last_idx   = len_reg - 11'd1;
        level_len  = 11'(bus.fifo_rd_water_level);
        full_ok    = enable && (32'(bus.fifo_rd_water_level) >= FULL_LEVEL);
        timeout_ok = enable && !bus.fifo_rd_empty && (timer_reg == TIMER_LAST)
                     && (level_len != 11'd0);
        pop        = (occ_reg != 2'd0) && bus.m_ready;
        // Issue only if the word can still land in the buffer after this cycle's pop.
        rd_en      = rd_rst_n && (state_reg == BURST) && (issued_reg < len_reg)
                     && !bus.fifo_rd_empty
                     && (({1'b0, occ_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop}));
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state_reg        <= IDLE;
            timer_reg        <= '0;
            issued_reg       <= '0;
            out_cnt_reg      <= '0;
            len_reg          <= '0;
            burst_cnt_reg    <= '0;
            occ_reg          <= '0;
            inflight_reg     <= 1'b0;
            inflight_sop_reg <= 1'b0;
            inflight_eop_reg <= 1'b0;
            head_reg         <= '0;
            tail_reg         <= '0;
        end else begin
            inflight_reg <= rd_en;
            if (rd_en) begin
                inflight_sop_reg <= (issued_reg == 11'd0);
                inflight_eop_reg <= (issued_reg == last_idx);
            end

            // Returned word lands in the first free slot after any pop shifts the buffer.
            case ({inflight_reg, pop})
                2'b10: begin
                    if (occ_reg == 2'd0) head_reg <= in_entry;
                    else                 tail_reg <= in_entry;
                    occ_reg <= occ_reg + 2'd1;
                end
                2'b01: begin
                    head_reg <= tail_reg;
                    occ_reg  <= occ_reg - 2'd1;
                end
                2'b11: begin
                    if (occ_reg == 2'd1) begin
                        head_reg <= in_entry;
                    end else begin
                        head_reg <= tail_reg;
                        tail_reg <= in_entry;
                    end
                end
                default: ;
            endcase

            case (state_reg)
                IDLE: begin
                    if (full_ok || timeout_ok) begin
                        state_reg   <= BURST;
                        len_reg     <= full_ok ? FULL_LEN : level_len;
                        issued_reg  <= '0;
                        out_cnt_reg <= '0;
                        timer_reg   <= '0;
                    end else if (enable && !bus.fifo_rd_empty) begin
                        timer_reg <= timer_reg + 16'd1;
                    end else begin
                        timer_reg <= '0;
                    end
                end
                BURST: begin
                    if (rd_en) issued_reg <= issued_reg + 11'd1;
                    if (pop) begin
                        out_cnt_reg <= out_cnt_reg + 11'd1;
                        if (out_cnt_reg == last_idx) begin
                            state_reg     <= GAP;
                            burst_cnt_reg <= burst_cnt_reg + 16'd1;
                        end
                    end
                end
                GAP:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_data     = head_reg.data;
    assign bus.m_valid    = (occ_reg != 2'd0);
    assign bus.m_sop      = (occ_reg != 2'd0) && head_reg.sop;
    assign bus.m_eop      = (occ_reg != 2'd0) && head_reg.eop;
    assign bus.m_len      = len_reg;
    assign busy           = (state_reg != IDLE);
    assign burst_cnt      = burst_cnt_reg;
endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Directed bench for fifo_burst_rd_ctrl: a counting FIFO model feeds the DUT and
// every accepted word is checked for order and framing.
module tb_fifo_burst_rd_ctrl;
    logic        clk = 1'b0;
    logic        rd_rst_n;
    logic        enable;
    logic        busy;
    logic [15:0] burst_cnt;
    logic        force_empty;
    int          wr_total = 0;
    int          rd_total = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    fifo_burst_rd_ctrl_if #(.RD_DATA_WIDTH(16), .RD_DEPTH_WIDTH(11)) bus ();

    fifo_burst_rd_ctrl #(
        .RD_DATA_WIDTH(16), .RD_DEPTH_WIDTH(11), .BURST_LEN(64), .TIMEOUT_CYC(256)
    ) dut (
        .rd_clk(clk), .rd_rst_n(rd_rst_n), .enable(enable),
        .bus(bus), .busy(busy), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: word value equals its read index, so order errors show up as data errors.
    assign bus.fifo_rd_water_level = 12'(wr_total - rd_total);
    assign bus.fifo_rd_empty       = (wr_total == rd_total) || force_empty;
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= 16'(rd_total);
            rd_total         <= rd_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int first, input bit toggle, input int drop_at,
                           input int empty_at, input int rst_at,
                           output int words, output int data_err, output int sop_idx,
                           output int sop_n, output int eop_idx, output int eop_n,
                           output int span, output int max_out, output int rd_in_empty,
                           output int timed_out);
        int cyc, outst, first_hs, empty_left;
        bit hs, rd, done, empty_started;
        words = 0; data_err = 0; sop_idx = -1; sop_n = 0; eop_idx = -1; eop_n = 0;
        span = 0; max_out = 0; rd_in_empty = 0; timed_out = 0;
        cyc = 0; outst = 0; first_hs = -1; empty_left = 0; done = 0; empty_started = 0;
        while (!done) begin
            tick();
            bus.m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (words == drop_at) enable = 1'b0;
            if (words == empty_at && !empty_started) begin
                empty_started = 1;
                empty_left    = 3;
            end
            force_empty = (empty_left > 0);
            if (empty_left > 0) empty_left--;
            if (words == rst_at) begin
                rd_rst_n = 1'b0;
                enable   = 1'b0;
                done     = 1;
            end else begin
                #1;
                hs = bus.m_valid && bus.m_ready;
                rd = bus.fifo_rd_en;
                if (force_empty && rd) rd_in_empty++;
                outst = outst + int'(rd) - int'(hs);
                if (outst > max_out) max_out = outst;
                if (hs) begin
                    if (bus.m_data !== 16'(first + words)) data_err++;
                    if (bus.m_sop) begin
                        sop_n++;
                        if (sop_idx < 0) sop_idx = words;
                    end
                    if (bus.m_eop) begin
                        eop_n++;
                        if (eop_idx < 0) eop_idx = words;
                        done = 1;
                    end
                    if (first_hs < 0) first_hs = cyc;
                    span = cyc - first_hs;
                    words++;
                end
                cyc++;
                if (cyc >= 3000) begin
                    timed_out = 1;
                    done      = 1;
                end
            end
        end
        force_empty = 1'b0;
    endtask

    task automatic close_burst(input string tag, input int exp_cnt);
        tick();
        check({tag, " busy_gap"}, busy, 1);
        check({tag, " burst_cnt"}, burst_cnt, exp_cnt);
        tick();
        check({tag, " busy_idle"}, busy, 0);
    endtask

    initial begin
        int words, data_err, sop_idx, sop_n, eop_idx, eop_n, span, max_out, rd_in_empty, timed_out;
        int n, busy_seen;

        rd_rst_n = 1'b0; enable = 1'b0; force_empty = 1'b0; bus.m_ready = 1'b1;
        repeat (3) tick();
        check("rst m_valid", bus.m_valid, 0);
        check("rst fifo_rd_en", bus.fifo_rd_en, 0);
        check("rst busy", busy, 0);
        check("rst burst_cnt", burst_cnt, 0);
        check("rst m_len", bus.m_len, 0);
        check("rst m_data", bus.m_data, 0);
        check("rst m_sop", bus.m_sop, 0);
        check("rst m_eop", bus.m_eop, 0);
        rd_rst_n = 1'b1;
        tick();

        // Reset at word 20 of the first burst.
        wr_total = 64; enable = 1'b1;
        collect(rd_total, 0, -1, -1, 20, words, data_err, sop_idx, sop_n, eop_idx, eop_n,
                span, max_out, rd_in_empty, timed_out);
        check("abort words", words, 20);
        check("abort data", data_err, 0);
        check("abort sop_idx", sop_idx, 0);
        tick();
        check("abort m_valid", bus.m_valid, 0);
        check("abort busy", busy, 0);
        check("abort burst_cnt", burst_cnt, 0);
        check("abort fifo_rd_en", bus.fifo_rd_en, 0);
        rd_rst_n = 1'b1;
        tick();
        check("abort m_valid2", bus.m_valid, 0);

        // Full 64-word burst, m_ready held high.
        wr_total = rd_total + 64; enable = 1'b1;
        n = rd_total;
        collect(rd_total, 0, -1, -1, -1, words, data_err, sop_idx, sop_n, eop_idx, eop_n,
                span, max_out, rd_in_empty, timed_out);
        check("full timeout", timed_out, 0);
        check("full words", words, 64);
        check("full data", data_err, 0);
        check("full sop_idx", sop_idx, 0);
        check("full sop_n", sop_n, 1);
        check("full eop_idx", eop_idx, 63);
        check("full eop_n", eop_n, 1);
        check("full span", span, 63);
        check("full m_len", bus.m_len, 64);
        check("full reads", rd_total - n, 64);
        close_burst("full", 1);

        // Partial burst of 5 after the idle timeout.
        wr_total = rd_total + 5;
        n = 0;
        busy_seen = 0;
        while (!busy_seen && n < 400) begin
            tick();
            n++;
            busy_seen = busy;
        end
        check("tmo cycles", n, 256);
        collect(rd_total, 0, -1, -1, -1, words, data_err, sop_idx, sop_n, eop_idx, eop_n,
                span, max_out, rd_in_empty, timed_out);
        check("tmo timeout", timed_out, 0);
        check("tmo words", words, 5);
        check("tmo data", data_err, 0);
        check("tmo sop_idx", sop_idx, 0);
        check("tmo eop_idx", eop_idx, 4);
        check("tmo m_len", bus.m_len, 5);
        close_burst("tmo", 2);

        // m_ready toggling every cycle.
        wr_total = rd_total + 64;
        collect(rd_total, 1, -1, -1, -1, words, data_err, sop_idx, sop_n, eop_idx, eop_n,
                span, max_out, rd_in_empty, timed_out);
        check("tog timeout", timed_out, 0);
        check("tog words", words, 64);
        check("tog data", data_err, 0);
        check("tog eop_idx", eop_idx, 63);
        check("tog occ_le_2", (max_out <= 2), 1);
        close_burst("tog", 3);

        // enable dropped at word 10, with another full burst waiting.
        bus.m_ready = 1'b1;
        wr_total = rd_total + 128;
        collect(rd_total, 0, 10, -1, -1, words, data_err, sop_idx, sop_n, eop_idx, eop_n,
                span, max_out, rd_in_empty, timed_out);
        check("den timeout", timed_out, 0);
        check("den words", words, 64);
        check("den data", data_err, 0);
        check("den eop_idx", eop_idx, 63);
        close_burst("den", 4);
        busy_seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            busy_seen += int'(busy);
        end
        check("den no_restart", busy_seen, 0);

        // FIFO empty forced for 3 cycles at word 30.
        enable = 1'b1;
        collect(rd_total, 0, -1, 30, -1, words, data_err, sop_idx, sop_n, eop_idx, eop_n,
                span, max_out, rd_in_empty, timed_out);
        check("emp timeout", timed_out, 0);
        check("emp rd_while_empty", rd_in_empty, 0);
        check("emp words", words, 64);
        check("emp data", data_err, 0);
        check("emp eop_idx", eop_idx, 63);
        enable = 1'b0;
        close_burst("emp", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
